// File: rtl/uio_host_bus_pkg.sv
`default_nettype none
// ============================================================================
//  uio_host_bus_pkg
//  Shared state encoding, ui_in field positions and uio_oe drive constants.
//  Revision: 1.0
// ============================================================================
package uio_host_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_ISSUE = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_TURN     = 3'd4,
        ST_DRIVE    = 3'd5,
        ST_WAIT_LOW = 3'd6,
        ST_RELEASE  = 3'd7
    } state_t;

    localparam int STB_BIT  = 0;
    localparam int RW_BIT   = 1;
    localparam int ADDR_LSB = 2;

    localparam logic [7:0] OE_DRIVE = 8'hFF;
    localparam logic [7:0] OE_IN    = 8'h00;

endpackage
`default_nettype wire

// File: rtl/uio_host_bus_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  sync_edge_det
//  Multi-flop synchronizer for an asynchronous strobe with rise/fall pulses.
//  Revision: 1.0
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    generate
        if (SYNC_STAGES < 2) begin : g_stage_check
            $error("sync_edge_det: SYNC_STAGES must be at least 2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_d_msb;
    logic                   prev_q;

    assign sync_d_msb = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_d_msb;
        end
    end

    assign level_o = sync_d_msb;
    assign rise_o  = sync_d_msb & ~prev_q;
    assign fall_o  = ~sync_d_msb & prev_q;

endmodule
`default_nettype wire

// File: rtl/uio_host_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  uio_host_bus_ctrl
//  Strobe-handshake command sequencer and uio bus turnaround owner.
//  Revision: 1.0
// ============================================================================
module uio_host_bus_ctrl
    import uio_host_bus_pkg::*;
#(
    parameter int         ADDR_W      = 4,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT     = 15,
    parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [7:0]        ui_in,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_ready,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic stb_level;
    logic stb_rise;
    logic stb_fall_unused;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_stb_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (ui_in[STB_BIT]),
        .level_o (stb_level),
        .rise_o  (stb_rise),
        .fall_o  (stb_fall_unused)
    );

    generate
        if (ADDR_LSB + ADDR_W < 8) begin : g_ui_spare
            logic spare_unused;
            assign spare_unused = ^ui_in[7:ADDR_LSB+ADDR_W];
        end
    endgenerate

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        out_q;
    logic [7:0]        oe_q;
    logic              we_q;
    logic              re_q;
    logic              ack_q;
    logic              busy_q;
    logic              err_q;
    logic [CNT_W-1:0]  tmo_cnt_q;
    logic [CNT_W-1:0]  tmo_cnt_d;
    logic              tmo_hit;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        tmo_hit   = (tmo_cnt_d == CNT_W'(TIMEOUT));
    end

    // All outputs are registered here so the pins never see decode glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            out_q     <= '0;
            oe_q      <= OE_IN;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (stb_rise && ena) begin
                        addr_q  <= ui_in[ADDR_LSB +: ADDR_W];
                        wdata_q <= uio_in;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        if (ui_in[RW_BIT]) begin
                            re_q    <= 1'b1;
                            state_q <= ST_RD_ISSUE;
                        end else begin
                            we_q    <= 1'b1;
                            state_q <= ST_WR_ISSUE;
                        end
                    end
                end
                ST_WR_ISSUE: begin
                    ack_q   <= 1'b1;
                    state_q <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!stb_level) begin
                        ack_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    // Data arriving on the terminal count still wins over the timeout.
                    if (reg_ready) begin
                        out_q   <= reg_rdata;
                        state_q <= ST_TURN;
                    end else if (tmo_hit) begin
                        out_q   <= ERR_BYTE;
                        err_q   <= 1'b1;
                        state_q <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    oe_q    <= OE_DRIVE;
                    ack_q   <= 1'b1;
                    state_q <= ST_DRIVE;
                end
                ST_DRIVE: begin
                    if (!stb_level) begin
                        oe_q    <= OE_IN;
                        ack_q   <= 1'b0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    oe_q    <= OE_IN;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign uio_out   = out_q;
    assign uio_oe    = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign ack       = ack_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uio_host_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_uio_host_bus_ctrl
//  Scoreboard bench: stimulus pushes expected bus events, a monitor pops them.
//  Revision: 1.0
// ============================================================================
module tb_uio_host_bus_ctrl;

    localparam int K_WE  = 0;
    localparam int K_RE  = 1;
    localparam int K_ACK = 2;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       ena       = 1'b0;
    logic [7:0] ui_in     = 8'h00;
    logic [7:0] uio_in    = 8'h00;
    logic [7:0] reg_rdata = 8'h5F;
    logic       reg_ready = 1'b0;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic       ack;
    logic       busy;
    logic       err;

    uio_host_bus_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .ui_in     (ui_in),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_ready (reg_ready),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] oe;
        logic       err;
        logic       chk_data;
    } exp_t;

    exp_t sbq[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] a, input logic [7:0] d,
                        input logic [7:0] oe, input logic e, input logic cd);
        exp_t x;
        x.kind = kind; x.addr = a; x.data = d; x.oe = oe; x.err = e; x.chk_data = cd;
        sbq.push_back(x);
    endtask

    // Register-file model: answers reg_re after rd_delay cycles (negative = never).
    int         rd_delay = 0;
    logic [7:0] rd_val   = 8'h00;

    always begin
        @(negedge clk);
        if (reg_re && rd_delay >= 0) begin
            repeat (rd_delay) @(negedge clk);
            reg_ready = 1'b1;
            reg_rdata = rd_val;
            @(negedge clk);
            reg_ready = 1'b0;
            reg_rdata = 8'h5F;
        end
    end

    // Monitor: statistics plus scoreboard pops on every DUT-presented event.
    int         cyc = 0, we_tot = 0, re_tot = 0, ack_tot = 0, drive_tot = 0, bad_oe = 0;
    int         last_re_cyc = 0, last_we_cyc = 0, last_ack_cyc = 0, drive_start = 0;
    logic [7:0] turn_out = 8'h00, prev_out = 8'h00, prev_oe = 8'h00;
    logic       prev_ack = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (reg_we) begin
            we_tot++;
            last_we_cyc = cyc;
            if (sbq.size() == 0) chk("sb_unexpected_we", 0, 1);
            else begin
                e = sbq.pop_front();
                chk("sb_we_kind", e.kind, K_WE);
                chk("sb_we_addr", reg_addr, e.addr);
                chk("sb_we_data", reg_wdata, e.data);
            end
        end
        if (reg_re) begin
            re_tot++;
            last_re_cyc = cyc;
            if (sbq.size() == 0) chk("sb_unexpected_re", 0, 1);
            else begin
                e = sbq.pop_front();
                chk("sb_re_kind", e.kind, K_RE);
                chk("sb_re_addr", reg_addr, e.addr);
            end
        end
        if (ack && !prev_ack) begin
            last_ack_cyc = cyc;
            if (sbq.size() == 0) chk("sb_unexpected_ack", 0, 1);
            else begin
                e = sbq.pop_front();
                chk("sb_ack_kind", e.kind, K_ACK);
                chk("sb_ack_oe", uio_oe, e.oe);
                chk("sb_ack_err", err, e.err);
                if (e.chk_data) chk("sb_ack_data", uio_out, e.data);
            end
        end
        if (ack) ack_tot++;
        if (uio_oe == 8'hFF) drive_tot++;
        if (uio_oe != 8'h00 && uio_oe != 8'hFF) bad_oe++;
        if (uio_oe == 8'hFF && prev_oe == 8'h00) begin
            drive_start = cyc;
            turn_out    = prev_out;
        end
        prev_ack = ack;
        prev_oe  = uio_oe;
        prev_out = uio_out;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic rw, input logic [3:0] a, input logic [7:0] d);
        ui_in  = {2'b00, a, rw, ui_in[0]};
        uio_in = d;
    endtask

    task automatic wait_ack(input string name);
        for (int i = 0; i < 40; i++) begin
            if (ack) break;
            step();
        end
        chk(name, ack, 1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            step();
        end
        chk(name, busy, 0);
    endtask

    int b_we, b_re, b_ack, b_drv;

    task automatic snap();
        b_we = we_tot; b_re = re_tot; b_ack = ack_tot; b_drv = drive_tot;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_oe", uio_oe, 8'h00);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_out", uio_out, 8'h00);
        chk("rst_addr", reg_addr, 4'h0);
        rst_n = 1'b1;
        ena   = 1'b1;
        step();

        // Write 8'h5A to address 3
        snap();
        set_cmd(1'b0, 4'h3, 8'h5A);
        step();
        push(K_WE, 8'h03, 8'h5A, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        ui_in[0] = 1'b1;
        wait_ack("wr_ack_seen");
        chk("wr_ack_latency", last_ack_cyc - last_we_cyc, 1);
        step(); step();
        chk("wr_ack_held", ack, 1);
        ui_in[0] = 1'b0;
        b_ack = ack_tot;
        repeat (5) step();
        chk("wr_ack_after_fall", ack_tot - b_ack, 2);
        chk("wr_we_pulses", we_tot - b_we, 1);
        chk("wr_no_re", re_tot - b_re, 0);
        chk("wr_no_drive", drive_tot - b_drv, 0);
        chk("wr_busy_end", busy, 0);
        chk("wr_addr_hold", reg_addr, 4'h3);
        chk("wr_data_hold", reg_wdata, 8'h5A);

        // Read, data ready two cycles after reg_re
        rd_delay = 2; rd_val = 8'hC3;
        set_cmd(1'b1, 4'h7, 8'h00);
        step();
        push(K_RE, 8'h07, 8'h00, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'hC3, 8'hFF, 1'b0, 1'b1);
        ui_in[0] = 1'b1;
        wait_ack("rd_ack_seen");
        chk("rd_turn_latency", drive_start - last_re_cyc, 4);
        chk("rd_turn_data", turn_out, 8'hC3);
        chk("rd_busy_drive", busy, 1);
        step(); step();
        ui_in[0] = 1'b0;
        step(); step();
        chk("rd_still_drive", uio_oe, 8'hFF);
        step();
        chk("rd_release_oe", uio_oe, 8'h00);
        chk("rd_release_ack", ack, 0);
        chk("rd_release_busy", busy, 1);
        chk("rd_release_out", uio_out, 8'hC3);
        step();
        chk("rd_idle_busy", busy, 0);

        // Read that times out
        rd_delay = -1;
        set_cmd(1'b1, 4'h9, 8'h00);
        step();
        push(K_RE, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'hEE, 8'hFF, 1'b1, 1'b1);
        ui_in[0] = 1'b1;
        wait_ack("tmo_ack_seen");
        chk("tmo_latency", drive_start - last_re_cyc, 17);
        chk("tmo_turn_data", turn_out, 8'hEE);
        ui_in[0] = 1'b0;
        wait_idle("tmo_idle");
        chk("tmo_err_sticky", err, 1);

        // Next accepted strobe clears err
        set_cmd(1'b0, 4'hA, 8'h11);
        step();
        push(K_WE, 8'h0A, 8'h11, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        ui_in[0] = 1'b1;
        wait_ack("clr_ack_seen");
        chk("clr_err", err, 0);
        ui_in[0] = 1'b0;
        wait_idle("clr_idle");

        // Ready on the exact terminal-count cycle
        rd_delay = 15; rd_val = 8'h3C;
        set_cmd(1'b1, 4'h4, 8'h00);
        step();
        push(K_RE, 8'h04, 8'h00, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h3C, 8'hFF, 1'b0, 1'b1);
        ui_in[0] = 1'b1;
        wait_ack("edge_ack_seen");
        chk("edge_latency", drive_start - last_re_cyc, 17);
        chk("edge_err", err, 0);
        ui_in[0] = 1'b0;
        wait_idle("edge_idle");

        // One-clock strobe pulse, then a second rise while busy
        rd_delay = 3; rd_val = 8'h96;
        set_cmd(1'b1, 4'h5, 8'h00);
        step();
        snap();
        push(K_RE, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h96, 8'hFF, 1'b0, 1'b1);
        ui_in[0] = 1'b1; step();
        ui_in[0] = 1'b0; step(); step();
        ui_in[0] = 1'b1; step();
        ui_in[0] = 1'b0;
        repeat (15) step();
        chk("pulse_re_once", re_tot - b_re, 1);
        chk("pulse_no_we", we_tot - b_we, 0);
        chk("pulse_ack_1cyc", ack_tot - b_ack, 1);
        chk("pulse_drive_1cyc", drive_tot - b_drv, 1);
        chk("pulse_idle", busy, 0);

        // Asynchronous reset in the middle of DRIVE
        rd_delay = 1; rd_val = 8'h77;
        set_cmd(1'b1, 4'h2, 8'h00);
        step();
        push(K_RE, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h77, 8'hFF, 1'b0, 1'b1);
        ui_in[0] = 1'b1;
        wait_ack("rst_mid_ack_seen");
        chk("rst_mid_driving", uio_oe, 8'hFF);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_oe_async", uio_oe, 8'h00);
        chk("rst_mid_ack_async", ack, 0);
        chk("rst_mid_busy_async", busy, 0);
        ui_in[0] = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step(); step();

        // Strobe with ena low, then ena raised while strobe still high
        snap();
        ena = 1'b0;
        set_cmd(1'b0, 4'h4, 8'h99);
        step();
        ui_in[0] = 1'b1;
        repeat (4) step();
        ena = 1'b1;
        repeat (5) step();
        chk("ena0_no_we", we_tot - b_we, 0);
        chk("ena0_no_re", re_tot - b_re, 0);
        chk("ena0_no_ack", ack_tot - b_ack, 0);
        chk("ena0_no_drive", drive_tot - b_drv, 0);
        chk("ena0_idle", busy, 0);
        ui_in[0] = 1'b0;
        repeat (4) step();

        // Fresh rise after recovery
        set_cmd(1'b0, 4'hF, 8'hA5);
        step();
        push(K_WE, 8'h0F, 8'hA5, 8'h00, 1'b0, 1'b0);
        push(K_ACK, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        ui_in[0] = 1'b1;
        wait_ack("final_ack_seen");
        ui_in[0] = 1'b0;
        wait_idle("final_idle");
        repeat (3) step();

        chk("bad_oe_values", bad_oe, 0);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
